// File: rtl/pong_pkg.sv
// Shared pong playfield constants, FSM state type and the paddle cover test
// used by both the ball engine and the matrix render stage.
package pong_pkg;

    localparam int WIDTH        = 16;
    localparam int SIZE         = 4;
    localparam int BIT_OF_WIDTH = 4;

    localparam logic [BIT_OF_WIDTH-1:0] CENTRE = BIT_OF_WIDTH'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_MOVE  = 2'd2,
        ST_MISS  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SIDE_TOP   = 2'd0,
        SIDE_DOWN  = 2'd1,
        SIDE_LEFT  = 2'd2,
        SIDE_RIGHT = 2'd3
    } side_t;

    // One extra bit so WIDTH-p-SIZE and friends never wrap.
    function automatic logic covers(input logic [2:0] p,
                                    input logic [BIT_OF_WIDTH-1:0] coord,
                                    input side_t side);
        logic [BIT_OF_WIDTH:0] lo;
        logic [BIT_OF_WIDTH:0] c;
        c = (BIT_OF_WIDTH+1)'(coord);
        case (side)
            SIDE_LEFT, SIDE_DOWN: lo = (BIT_OF_WIDTH+1)'(p);
            SIDE_RIGHT:           lo = (BIT_OF_WIDTH+1)'(WIDTH - 2) - (BIT_OF_WIDTH+1)'(p);
            default:              lo = (BIT_OF_WIDTH+1)'(WIDTH - SIZE) - (BIT_OF_WIDTH+1)'(p);
        endcase
        return (c >= lo) && (c <= lo + (BIT_OF_WIDTH+1)'(SIZE - 1));
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks,
// with a synchronous clear to realign the tick phase.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Pong ball motion: steps the ball once per tick, reflects off covering
// paddles, and flags misses on each of the four sides.
module ball_engine
    import pong_pkg::*;
#(
    parameter int TICK_DIV   = 1_000_000,
    parameter int HOLD_TICKS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2:0]                player_top,
    input  logic [2:0]                player_down,
    input  logic [2:0]                player_left,
    input  logic [2:0]                player_right,
    output logic [2*BIT_OF_WIDTH-1:0] pos_ball,
    output logic                      miss_top,
    output logic                      miss_down,
    output logic                      miss_left,
    output logic                      miss_right,
    output logic                      running
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef struct packed {
        logic [BIT_OF_WIDTH-1:0] pos;
        logic                    dir;
        logic                    miss_lo;
        logic                    miss_hi;
    } axis_t;

    // One axis step: reflect at an edge if the paddle covers, else flag a miss.
    function automatic axis_t axis_step(input logic [BIT_OF_WIDTH-1:0] pos,
                                        input logic dir,
                                        input logic cov_lo,
                                        input logic cov_hi);
        axis_t r;
        r.pos     = pos;
        r.dir     = dir;
        r.miss_lo = 1'b0;
        r.miss_hi = 1'b0;
        if (!dir && pos == BIT_OF_WIDTH'(1)) begin
            if (cov_lo) begin
                r.dir = 1'b1;
                r.pos = BIT_OF_WIDTH'(2);
            end else begin
                r.miss_lo = 1'b1;
            end
        end else if (dir && pos == BIT_OF_WIDTH'(WIDTH - 2)) begin
            if (cov_hi) begin
                r.dir = 1'b0;
                r.pos = BIT_OF_WIDTH'(WIDTH - 3);
            end else begin
                r.miss_hi = 1'b1;
            end
        end else begin
            r.pos = dir ? pos + 1'b1 : pos - 1'b1;
        end
        return r;
    endfunction

    state_t                  r_state;
    logic [BIT_OF_WIDTH-1:0] r_x;
    logic [BIT_OF_WIDTH-1:0] r_y;
    logic                    r_dx;
    logic                    r_dy;
    logic [HW-1:0]           r_hold;
    logic                    r_miss_top, r_miss_down, r_miss_left, r_miss_right;

    logic  w_tick;
    logic  w_clr;
    logic  w_miss;
    axis_t w_ax;
    axis_t w_ay;

    assign w_clr = (r_state == ST_SERVE);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        w_ax = axis_step(r_x, r_dx, covers(player_left, r_y, SIDE_LEFT),
                         covers(player_right, r_y, SIDE_RIGHT));
        w_ay = axis_step(r_y, r_dy, covers(player_top, r_x, SIDE_TOP),
                         covers(player_down, r_x, SIDE_DOWN));
    end

    assign w_miss = w_ax.miss_lo | w_ax.miss_hi | w_ay.miss_lo | w_ay.miss_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= CENTRE;
            r_y          <= CENTRE;
            r_dx         <= 1'b1;
            r_dy         <= 1'b1;
            r_hold       <= '0;
            r_miss_top   <= 1'b0;
            r_miss_down  <= 1'b0;
            r_miss_left  <= 1'b0;
            r_miss_right <= 1'b0;
        end else begin
            r_miss_top   <= 1'b0;
            r_miss_down  <= 1'b0;
            r_miss_left  <= 1'b0;
            r_miss_right <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_SERVE;
                end
                ST_SERVE: begin
                    r_x     <= CENTRE;
                    r_y     <= CENTRE;
                    r_state <= ST_MOVE;
                end
                ST_MOVE: begin
                    if (w_tick) begin
                        if (w_miss) begin
                            // Freeze the ball and serve back toward the other side.
                            r_miss_left  <= w_ax.miss_lo;
                            r_miss_right <= w_ax.miss_hi;
                            r_miss_top   <= w_ay.miss_lo;
                            r_miss_down  <= w_ay.miss_hi;
                            r_dx         <= ~r_dx;
                            r_dy         <= w_ay.dir;
                            r_hold       <= '0;
                            r_state      <= ST_MISS;
                        end else begin
                            r_x  <= w_ax.pos;
                            r_y  <= w_ay.pos;
                            r_dx <= w_ax.dir;
                            r_dy <= w_ay.dir;
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        if (r_hold == HW'(HOLD_TICKS - 1)) begin
                            r_state <= ST_SERVE;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pos_ball   = {r_x, r_y};
    assign miss_top   = r_miss_top;
    assign miss_down  = r_miss_down;
    assign miss_left  = r_miss_left;
    assign miss_right = r_miss_right;
    assign running    = (r_state != ST_IDLE);

endmodule
